match_event_monitor: RTL and testbench

- Consumes the single-bit match output `z` of `sequence_detector` (pattern "101010").
- Keeps a saturating count of all matches.
- Raises a sticky alarm when THRESH matches occur within a sliding window of WIN_LEN clock edges, opened by the first match.
- Sits directly downstream of the detector and feeds status/interrupt logic.

---
 rtl/match_event_monitor.sv | 153 +++++++++++++++
 tb/tb_match_event_monitor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_event_monitor.sv
// match_event_monitor
// Watches the single-bit match pulse of an upstream sequence detector.
// Keeps a saturating total of matches and raises a sticky alarm when
// THRESH matches land inside one WIN_LEN-edge window opened by a match.
// All outputs are registered; `reset` is asynchronous and active-low,
// `clear` is a synchronous equivalent, and enable=0 freezes everything.

module match_event_monitor #(
  parameter int CNT_W   = 8,
  parameter int WIN_LEN = 16,
  parameter int THRESH  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             z,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] total_count,
  output logic [CNT_W-1:0] win_count,
  output logic             alarm,
  output logic             overflow,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    ALARM  = 2'd2
  } state_e;

  // WIN_LEN is at most 255, so an 8-bit edge counter always suffices.
  localparam int TMR_W = 8;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_LEN - 1);
  localparam logic [CNT_W:0]   THRESH_W = (CNT_W + 1)'(THRESH);

  state_e             state_q,    state_d;
  logic [CNT_W-1:0]   total_q,    total_d;
  logic [CNT_W-1:0]   win_q,      win_d;
  logic               alarm_q,    alarm_d;
  logic               overflow_q, overflow_d;
  // Number of window edges already consumed; the edge that opens the
  // window counts as the first one, so the last edge sees TMR_LAST.
  logic [TMR_W-1:0]   timer_q,    timer_d;

  logic               win_hit;

  // A match in WINDOW reaches the threshold when win_count+1 == THRESH.
  // One extra bit keeps the comparison exact even if THRESH needs it.
  assign win_hit = (({1'b0, win_q} + (CNT_W + 1)'(1)) == THRESH_W);

  // Next-state and next-output computation for counters, flags and FSM.
  always_comb begin
    // NOTE: every _d starts as its _q so that each path through the
    // branches below assigns it; a missing default would infer a latch.
    state_d    = state_q;
    total_d    = total_q;
    win_d      = win_q;
    alarm_d    = alarm_q;
    overflow_d = overflow_q;
    timer_d    = timer_q;

    if (clear) begin
      state_d    = IDLE;
      total_d    = '0;
      win_d      = '0;
      alarm_d    = 1'b0;
      overflow_d = 1'b0;
      timer_d    = '0;
    end else if (enable) begin
      // Total count runs in every state and saturates at all-ones.
      if (z) begin
        if (&total_q) begin
          overflow_d = 1'b1;
        end else begin
          total_d = total_q + CNT_W'(1);
        end
      end

      unique case (state_q)
        IDLE: begin
          if (z) begin
            win_d = CNT_W'(1);
            if (THRESH == 1) begin
              state_d = ALARM;
              alarm_d = 1'b1;
            end else begin
              state_d = WINDOW;
              timer_d = TMR_W'(1);
            end
          end
        end

        WINDOW: begin
          if (z && win_hit) begin
            // Threshold wins even on the last window edge.
            state_d = ALARM;
            alarm_d = 1'b1;
            win_d   = win_q + CNT_W'(1);
            timer_d = '0;
          end else if (timer_q == TMR_LAST) begin
            state_d = IDLE;
            win_d   = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_W'(1);
            if (z) begin
              win_d = win_q + CNT_W'(1);
            end
          end
        end

        ALARM: begin
          // Absorbing: only clear or reset leave this state.
        end

        default: begin
          // Encoding 3 is never produced; fall back to a clean IDLE.
          state_d = IDLE;
          win_d   = '0;
          timer_d = '0;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      total_q    <= '0;
      win_q      <= '0;
      alarm_q    <= 1'b0;
      overflow_q <= 1'b0;
      timer_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed before this edge, independent of statement order.
      state_q    <= state_d;
      total_q    <= total_d;
      win_q      <= win_d;
      alarm_q    <= alarm_d;
      overflow_q <= overflow_d;
      timer_q    <= timer_d;
    end
  end

  assign total_count = total_q;
  assign win_count   = win_q;
  assign alarm       = alarm_q;
  assign overflow    = overflow_q;
  assign state       = state_q;

endmodule

// File: tb/tb_match_event_monitor.sv
// Testbench for match_event_monitor.
// Three instances with different parameters share one stimulus stream.
// A driver steps a behavioural model per instance and queues the expected
// outputs; a separate monitor pops one entry per clock edge and compares.
// Directed checks against fixed constants cover the named scenarios.

module tb_match_event_monitor;

  // Instance A: default parameters.
  localparam int A_CW = 8, A_WL = 16, A_TH = 3;
  // Instance B: narrow counter, threshold equal to the window length.
  localparam int B_CW = 4, B_WL = 4,  B_TH = 4;
  // Instance C: single-match alarm.
  localparam int C_CW = 8, C_WL = 2,  C_TH = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic z = 1'b0;
  logic enable = 1'b1;
  logic clear = 1'b0;

  logic [A_CW-1:0] tot_a, win_a;
  logic [B_CW-1:0] tot_b, win_b;
  logic [C_CW-1:0] tot_c, win_c;
  logic al_a, al_b, al_c, ov_a, ov_b, ov_c;
  logic [1:0] st_a, st_b, st_c;

  always #5 clk = ~clk;

  match_event_monitor #(.CNT_W(A_CW), .WIN_LEN(A_WL), .THRESH(A_TH)) dut_a (
    .clk(clk), .reset(reset), .z(z), .enable(enable), .clear(clear),
    .total_count(tot_a), .win_count(win_a), .alarm(al_a),
    .overflow(ov_a), .state(st_a));

  match_event_monitor #(.CNT_W(B_CW), .WIN_LEN(B_WL), .THRESH(B_TH)) dut_b (
    .clk(clk), .reset(reset), .z(z), .enable(enable), .clear(clear),
    .total_count(tot_b), .win_count(win_b), .alarm(al_b),
    .overflow(ov_b), .state(st_b));

  match_event_monitor #(.CNT_W(C_CW), .WIN_LEN(C_WL), .THRESH(C_TH)) dut_c (
    .clk(clk), .reset(reset), .z(z), .enable(enable), .clear(clear),
    .total_count(tot_c), .win_count(win_c), .alarm(al_c),
    .overflow(ov_c), .state(st_c));

  // Behavioural view: n counts enabled edges since reset/clear, and a
  // window is described by the edge number that opened it.
  typedef struct {
    int total;
    int win;
    int st;
    int alarm;
    int ovf;
    int n;
    int start;
  } mdl_t;

  mdl_t ma, mb, mc;
  mdl_t qa[$], qb[$], qc[$];

  int checks = 0;
  int errors = 0;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.total = 0; r.win = 0; r.st = 0; r.alarm = 0; r.ovf = 0;
    r.n = 0; r.start = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit clr, bit en, bit zz,
                                    int cw, int wl, int th);
    mdl_t r = m;
    if (clr) return mdl_reset();
    if (!en) return r;
    if (zz) begin
      if (r.total == (1 << cw) - 1) r.ovf = 1;
      else r.total = r.total + 1;
    end
    if (r.st == 0) begin
      if (zz) begin
        r.win = 1;
        if (th == 1) begin
          r.st = 2; r.alarm = 1;
        end else begin
          r.st = 1; r.start = r.n;
        end
      end
    end else if (r.st == 1) begin
      if (zz) r.win = r.win + 1;
      if (r.win == th) begin
        r.st = 2; r.alarm = 1;
      end else if (r.n == r.start + wl - 1) begin
        r.st = 0; r.win = 0;
      end
    end
    r.n = r.n + 1;
    return r;
  endfunction

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(string tag, mdl_t e, int tot, int win, int st,
                     int al, int ov);
    check({tag, ".total_count"}, tot, e.total);
    check({tag, ".win_count"},   win, e.win);
    check({tag, ".state"},       st,  e.st);
    check({tag, ".alarm"},       al,  e.alarm);
    check({tag, ".overflow"},    ov,  e.ovf);
  endtask

  // Monitor: one expected entry per instance is consumed after each edge.
  initial begin
    mdl_t e;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        cmp("sb_a", e, int'(tot_a), int'(win_a), int'(st_a), int'(al_a), int'(ov_a));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        cmp("sb_b", e, int'(tot_b), int'(win_b), int'(st_b), int'(al_b), int'(ov_b));
      end
      if (qc.size() > 0) begin
        e = qc.pop_front();
        cmp("sb_c", e, int'(tot_c), int'(win_c), int'(st_c), int'(al_c), int'(ov_c));
      end
    end
  end

  task automatic push_step(bit clr, bit en, bit zz);
    ma = mdl_step(ma, clr, en, zz, A_CW, A_WL, A_TH);
    mb = mdl_step(mb, clr, en, zz, B_CW, B_WL, B_TH);
    mc = mdl_step(mc, clr, en, zz, C_CW, C_WL, C_TH);
    qa.push_back(ma);
    qb.push_back(mb);
    qc.push_back(mc);
  endtask

  // One clock cycle of stimulus; returns once the edge has settled.
  task automatic cyc(bit clr, bit en, bit zz);
    @(negedge clk);
    clear = clr; enable = en; z = zz;
    push_step(clr, en, zz);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(string tag);
    check({tag, ".a_total"}, int'(tot_a), 0);
    check({tag, ".a_win"},   int'(win_a), 0);
    check({tag, ".a_state"}, int'(st_a),  0);
    check({tag, ".a_alarm"}, int'(al_a),  0);
    check({tag, ".a_ovf"},   int'(ov_a),  0);
    check({tag, ".b_total"}, int'(tot_b), 0);
    check({tag, ".c_state"}, int'(st_c),  0);
  endtask

  // Pulse reset low between edges, check outputs before the next edge,
  // then release and apply one normal cycle with the given z.
  task automatic reset_mid(bit zz);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_zero("async_reset");
    ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();
    #1;
    reset = 1'b1;
    clear = 1'b0; enable = 1'b1; z = zz;
    push_step(1'b0, 1'b1, zz);
    @(posedge clk);
    #2;
  endtask

  initial begin
    ma = mdl_reset(); mb = mdl_reset(); mc = mdl_reset();

    // Power-on reset.
    #3;
    chk_zero("por");
    @(negedge clk);
    #1;
    reset = 1'b1;

    // Asynchronous reset in the middle of an open window.
    cyc(0, 1, 1);
    cyc(0, 1, 0);
    cyc(0, 1, 1);
    check("pre_reset.win", int'(win_a), 2);
    check("pre_reset.state", int'(st_a), 1);
    reset_mid(0);
    cyc(0, 1, 1);
    check("post_reset.state", int'(st_a), 1);
    check("post_reset.win", int'(win_a), 1);

    // Threshold hit at edges 0, 2, 4.
    cyc(1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, (i % 2) == 0);
    check("thresh.alarm", int'(al_a), 1);
    check("thresh.state", int'(st_a), 2);
    check("thresh.win", int'(win_a), 3);
    check("thresh.total", int'(tot_a), 3);
    for (int i = 5; i < 9; i++) cyc(0, 1, (i % 2) == 0);
    check("thresh_more.total", int'(tot_a), 5);
    check("thresh_more.win", int'(win_a), 3);
    check("thresh_more.state", int'(st_a), 2);

    // Clear beats a coincident match.
    cyc(1, 1, 1);
    chk_zero("clear_z");

    // Disabled matches are ignored.
    for (int i = 0; i < 5; i++) cyc(0, 0, 1);
    chk_zero("disabled");

    // Window expiry: matches at edges 0 and 15 only.
    for (int i = 0; i < 16; i++) cyc(0, 1, (i == 0) || (i == 15));
    check("expire.state", int'(st_a), 0);
    check("expire.win", int'(win_a), 0);
    check("expire.alarm", int'(al_a), 0);
    cyc(0, 1, 1);
    check("reopen.state", int'(st_a), 1);
    check("reopen.win", int'(win_a), 1);
    check("reopen.total", int'(tot_a), 3);

    // Window timer freezes while disabled.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0);
    check("freeze.still_open", int'(st_a), 1);
    cyc(0, 1, 0);
    check("freeze.expired", int'(st_a), 0);
    check("freeze.total", int'(tot_a), 3);

    // Saturation on the 4-bit instance, matches every other edge.
    cyc(1, 1, 0);
    for (int p = 1; p <= 17; p++) begin
      cyc(0, 1, 1);
      if (p <= 15) begin
        check($sformatf("sat.total_p%0d", p), int'(tot_b), p);
        check($sformatf("sat.ovf_p%0d", p), int'(ov_b), 0);
      end else begin
        check($sformatf("sat.total_p%0d", p), int'(tot_b), 15);
        check($sformatf("sat.ovf_p%0d", p), int'(ov_b), 1);
      end
      check($sformatf("sat.no_alarm_p%0d", p), int'(al_b), 0);
      cyc(0, 1, 0);
    end

    // Single-match alarm.
    cyc(1, 1, 0);
    cyc(0, 1, 1);
    check("thresh1.state", int'(st_c), 2);
    check("thresh1.alarm", int'(al_c), 1);
    check("thresh1.win", int'(win_c), 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) reset_mid(1'($urandom_range(0, 1)));
      else cyc(r < 20, $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)));
    end

    cyc(0, 1, 0);
    cyc(0, 1, 0);
    #3;
    check("sb_drain", qa.size() + qb.size() + qc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
